// File: rtl/x74_serial_rx.sv
// ============================================================================
// x74_serial_rx
// ----------------------------------------------------------------------------
// Serial-to-parallel frame receiver for the 4-bit link driven by the
// 74194-style shift-register transmitter.
//
// Frame on sin (idle high), every bit BIT_CLKS ck cycles long:
//     start(0) | 4 data bits | [even parity] | stop(1)
//
// The start bit is confirmed at its midpoint, and every later bit is
// sampled one full bit period after the previous sample. A good frame is
// presented on qa..qd (qa = MSB) with a valid/rd handshake.
//
// Compile-time option:
//     X74_SERIAL_RX_PARITY_EN  - when defined, an even-parity bit follows the
//                                data bits. A parity mismatch is reported
//                                like a bad stop bit.
//
// Parameters:
//     BIT_CLKS   ck cycles per serial bit, legal range 2..255.
//
// Ports:
//     ck         in   clock, rising edge
//     clr        in   asynchronous active-low reset
//     sin        in   serial line, idle high, synchronous to ck
//     msb_first  in   bit order, latched when the start bit is detected
//     rd         in   consumer acknowledge, clears valid
//     qa..qd     out  received nibble, qa = bit 3 (MSB), qd = bit 0 (LSB)
//     valid      out  qa..qd hold a frame that has not been read
//     frame_err  out  one-cycle pulse on a bad stop bit (or bad parity)
//     overrun    out  sticky: a good frame was dropped because valid was high
// ============================================================================
module x74_serial_rx #(
    parameter int unsigned BIT_CLKS = 4
) (
    input  logic ck,
    input  logic clr,
    input  logic sin,
    input  logic msb_first,
    input  logic rd,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd,
    output logic valid,
    output logic frame_err,
    output logic overrun
);

    // Counter reload values. The start bit is re-checked half a bit after
    // it was first seen. Every other bit is sampled one full period later.
    localparam logic [7:0] HALF_PERIOD = 8'(BIT_CLKS / 2);
    localparam logic [7:0] FULL_PERIOD = 8'(BIT_CLKS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef X74_SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic [7:0]  cnt;        // cycles left until the next sample point
    logic [1:0]  bit_idx;    // data bit currently being received
    logic        order;      // msb_first as latched at start detection
    logic [3:0]  shreg;      // assembled nibble, bit 3 = qa
    logic        load_pend;  // good stop seen last cycle, hand frame over now
`ifdef X74_SERIAL_RX_PARITY_EN
    logic        par_acc;    // running XOR of the received data bits
    logic        par_bad;    // parity bit disagreed with the data
`endif

    // A sample point is reached when the counter has run down to 1. The
    // counter holds the number of edges remaining, including this one.
    logic sample_now;
    assign sample_now = (cnt == 8'd1);

    // NOTE: every register below is written with <= so that all of them see
    // the pre-edge values of each other, exactly like real flip-flops.
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            bit_idx   <= 2'd0;
            order     <= 1'b0;
            shreg     <= 4'd0;
            load_pend <= 1'b0;
            qa        <= 1'b0;
            qb        <= 1'b0;
            qc        <= 1'b0;
            qd        <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef X74_SERIAL_RX_PARITY_EN
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            // Single-cycle strobes default low.
            frame_err <= 1'b0;
            load_pend <= 1'b0;

            // ----------------------------------------------------------------
            // Consumer side. The hand-over happens one cycle after the stop
            // sample, while the receiver is already back in IDLE. shreg is
            // safe to read here because nothing shifts outside DATA.
            // ----------------------------------------------------------------
            if (load_pend) begin
                if (!valid || rd) begin
                    {qa, qb, qc, qd} <= shreg;
                    valid            <= 1'b1;
                    // An rd that meets valid=1 is an accepted read, even if
                    // a new frame replaces the old one in the same cycle.
                    if (valid && rd) begin
                        overrun <= 1'b0;
                    end
                end else begin
                    // Unread frame still held. Drop the new one.
                    overrun <= 1'b1;
                end
            end else if (valid && rd) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            // ----------------------------------------------------------------
            // Line-side receiver FSM
            // ----------------------------------------------------------------
            case (state)
                IDLE: begin
                    if (!sin) begin
                        state <= START;
                        cnt   <= HALF_PERIOD;
                        order <= msb_first;
                    end
                end

                START: begin
                    if (sample_now) begin
                        if (sin) begin
                            // Low pulse shorter than half a bit: a glitch.
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= FULL_PERIOD;
                            bit_idx <= 2'd0;
`ifdef X74_SERIAL_RX_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DATA: begin
                    if (sample_now) begin
                        // MSB-first data shifts in from the bottom, so the
                        // first bit ends up in qa. LSB-first data shifts in
                        // from the top, so the first bit ends up in qd.
                        if (order) begin
                            shreg <= {shreg[2:0], sin};
                        end else begin
                            shreg <= {sin, shreg[3:1]};
                        end
`ifdef X74_SERIAL_RX_PARITY_EN
                        par_acc <= par_acc ^ sin;
`endif
                        cnt <= FULL_PERIOD;
                        if (bit_idx == 2'd3) begin
`ifdef X74_SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

`ifdef X74_SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (sample_now) begin
                        // Even parity: data bits plus the parity bit must
                        // contain an even number of ones.
                        par_bad <= par_acc ^ sin;
                        state   <= STOP;
                        cnt     <= FULL_PERIOD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif

                STOP: begin
                    if (sample_now) begin
                        if (!sin) begin
                            // The line is held low, possibly a break. Wait
                            // for it to go high before looking for a new start.
                            frame_err <= 1'b1;
                            state     <= BREAK;
`ifdef X74_SERIAL_RX_PARITY_EN
                        end else if (par_bad) begin
                            // The stop bit is good but the data is corrupt.
                            // The line is high, so return straight to IDLE.
                            frame_err <= 1'b1;
                            state     <= IDLE;
`endif
                        end else begin
                            load_pend <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                BREAK: begin
                    if (sin) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x74_serial_rx.sv
// ============================================================================
// tb_x74_serial_rx
// ----------------------------------------------------------------------------
// Self-checking bench for x74_serial_rx at BIT_CLKS = 4. Frames are built as
// bit lists, and each bit is held on sin for BIT_CLKS cycles. The expected
// nibble, valid, overrun and frame_err behaviour comes from a small
// transaction-level model of the handshake. Directed cases run first, then
// a randomized run. Define X74_SERIAL_RX_PARITY_EN for both files to cover
// the parity build.
// ============================================================================
module tb_x74_serial_rx;

    localparam int B = 4;
`ifdef X74_SERIAL_RX_PARITY_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif
    // Stop sample: mid-start (B/2) plus one period per following bit.
    // valid rises one cycle after that sample.
    localparam int LAT = (FL - 1) * B + B / 2 + 1;

    logic ck = 1'b0;
    logic clr, sin, msb_first, rd;
    logic qa, qb, qc, qd, valid, frame_err, overrun;

    x74_serial_rx #(.BIT_CLKS(B)) dut (
        .ck        (ck),
        .clr       (clr),
        .sin       (sin),
        .msb_first (msb_first),
        .rd        (rd),
        .qa        (qa),
        .qb        (qb),
        .qc        (qc),
        .qd        (qd),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 ck = ~ck;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the consumer-visible state
    logic [3:0] m_q;
    logic       m_valid;
    logic       m_ovr;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_q"},     {28'd0, qa, qb, qc, qd}, {28'd0, m_q});
        check({tag, "_valid"}, {31'd0, valid},          {31'd0, m_valid});
        check({tag, "_ovr"},   {31'd0, overrun},        {31'd0, m_ovr});
    endtask

    // Send one frame. The nibble d is given as qa..qd, so d[3] is qa.
    // msb_first is applied on the start cycle and randomized afterwards.
    task automatic send_frame(input logic [3:0] d, input logic order,
                              input logic stop_bit, input logic par_bad,
                              input logic rd_load, input string tag);
        logic bits[$];
        int   fe_cnt = 0;
        logic v_pre = 1'b0;
        logic v_at  = 1'b0;
        logic prev_valid;
        logic good;
        bits.push_back(1'b0);
        for (int k = 0; k < 4; k++) begin
            bits.push_back(order ? d[3 - k] : d[k]);
        end
`ifdef X74_SERIAL_RX_PARITY_EN
        bits.push_back((^d) ^ par_bad);
`endif
        bits.push_back(stop_bit);
        good       = stop_bit && !par_bad;
        prev_valid = m_valid;

        for (int i = 0; i < FL * B; i++) begin
            sin       = bits[i / B];
            msb_first = (i == 0) ? order : 1'($urandom);
            rd        = rd_load && (i == LAT);
            tick();
            if (frame_err) fe_cnt++;
            if (i == LAT - 1) v_pre = valid;
            if (i == LAT) v_at = valid;
        end
        rd = 1'b0;

        if (good) begin
            if (!m_valid || rd_load) begin
                if (m_valid) m_ovr = 1'b0;
                m_q     = d;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end

        check({tag, "_vpre"}, {31'd0, v_pre}, {31'd0, prev_valid});
        check({tag, "_vlat"}, {31'd0, v_at},  {31'd0, m_valid});
        check({tag, "_ferr"}, fe_cnt,         good ? 0 : 1);
        check_state(tag);
    endtask

    task automatic rd_pulse(input string tag);
        sin = 1'b1;
        rd  = 1'b1;
        tick();
        rd = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        check_state(tag);
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        rd  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int fe_cnt;
        clr = 1'b0; sin = 1'b1; rd = 1'b0; msb_first = 1'b0;
        m_q = 4'd0; m_valid = 1'b0; m_ovr = 1'b0;
        repeat (2) tick();
        check_state("reset");
        check("reset_ferr", {31'd0, frame_err}, 0);
        clr = 1'b1;
        idle(3);

        // Basic MSB-first frame, with valid latency checked inside send_frame
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, "basic");
        rd_pulse("basic_rd");
        rd_pulse("rd_no_valid");
        idle(2);

        // LSB-first frame: wire order 1,0,0,0 gives 0001
        send_frame(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, "lsb");
        rd_pulse("lsb_rd");

        // A one-cycle low glitch must be ignored
        sin = 1'b0;
        tick();
        fe_cnt = 0;
        sin = 1'b1;
        repeat (3 * B) begin
            tick();
            if (frame_err) fe_cnt++;
        end
        check("glitch_ferr", fe_cnt, 0);
        check_state("glitch");
        send_frame(4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, "post_glitch");
        rd_pulse("post_glitch_rd");

        // Bad stop bit, then a long low line: one error only
        send_frame(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, "badstop");
        fe_cnt = 0;
        sin = 1'b0;
        repeat (8 * B) begin
            tick();
            if (frame_err) fe_cnt++;
        end
        check("break_ferr", fe_cnt, 0);
        check_state("break");
        idle(1);
        send_frame(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, "post_break");
        rd_pulse("post_break_rd");

        // Overrun on back-to-back frames, cleared by rd
        send_frame(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, "ovr_a");
        send_frame(4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, "ovr_b");
        rd_pulse("ovr_rd");

        // rd on the load cycle: the new frame replaces the old one
        send_frame(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, "rdload_a");
        send_frame(4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, "rdload_b");
        rd_pulse("rdload_rd");

`ifdef X74_SERIAL_RX_PARITY_EN
        send_frame(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, "par_good");
        rd_pulse("par_good_rd");
        send_frame(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, "par_bad");
        idle(1);
`endif

        // Reset in the middle of a frame with the line toggling
        send_frame(4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, "pre_rst_a");
        send_frame(4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, "pre_rst_b");
        for (int i = 0; i < 2 * B; i++) begin
            sin = (i < B) ? 1'b0 : 1'(i % 2);
            tick();
        end
        #2 clr = 1'b0;
        #1;
        m_q = 4'd0; m_valid = 1'b0; m_ovr = 1'b0;
        check_state("rst_async");
        check("rst_async_ferr", {31'd0, frame_err}, 0);
        for (int i = 0; i < 3; i++) begin
            sin = 1'(i % 2);
            tick();
        end
        check_state("rst_held");
        clr = 1'b1;
        idle(2);
        send_frame(4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, "post_rst");
        rd_pulse("post_rst_rd");

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0] d;
            logic       bad_stop, bad_par;
            d        = 4'($urandom);
            bad_stop = ($urandom_range(0, 7) == 0);
`ifdef X74_SERIAL_RX_PARITY_EN
            bad_par  = ($urandom_range(0, 7) == 0);
`else
            bad_par  = 1'b0;
`endif
            send_frame(d, 1'($urandom), !bad_stop, bad_par,
                       ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) rd_pulse($sformatf("rnd%0d_rd", n));
            idle($urandom_range(0, 3) + (bad_stop ? 1 : 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x74_serial_rx.md
Name: x74_serial_rx

Overview:
- Serial-to-parallel frame receiver, 4 data bits.
- Receiving end of the 4-bit serial link driven by the team's 74194-style shift-register transmitter.
- Detects the start bit, samples each bit mid-period, checks the stop bit, then presents the nibble on qa..qd with a valid/rd handshake.
- Overrun and framing errors are flagged.

Parameters:
- BIT_CLKS, 4, ck cycles per serial bit; legal range 2..255.

Ports:
- ck  input  1  clock, rising-edge.
- clr  input  1  asynchronous active-low reset.
- sin  input  1  serial line, idle high, synchronous to ck.
- msb_first  input  1  bit order select; sampled at start detection.
- rd  input  1  consumer acknowledge; clears valid.
- qa  output  1  data bit 3 (MSB).
- qb  output  1  data bit 2.
- qc  output  1  data bit 1.
- qd  output  1  data bit 0 (LSB).
- valid  output  1  qa..qd hold an unread frame.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- overrun  output  1  sticky; a completed frame was lost because valid was high.

Behaviour:
- Reset: clr low forces qa..qd=0, valid=0, frame_err=0, overrun=0, state IDLE, counters 0, immediately and independent of ck.
- Frame on sin: start bit 0, 4 data bits, [parity bit, see Optional Feature], stop bit 1. Each bit lasts BIT_CLKS cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: sin sampled 0 at cycle t0 -> START. Latch msb_first. Load the period counter with BIT_CLKS/2 (integer division).
- START: at t0+BIT_CLKS/2 (the mid-start sample), sin re-checked.
  - sin=1: glitch; return to IDLE with no flags.
  - sin=0: go to DATA, bit index 0.
- DATA: sample every BIT_CLKS cycles after the mid-start sample. Data bit k is sampled at mid-start + BIT_CLKS*(k+1), k=0..3, into an internal shift register.
  - msb_first=1: first bit received is qa, last is qd.
  - msb_first=0: first bit received is qd, last is qa.
  - After the 4th bit: go to PARITY if the feature is compiled in, else STOP.
- STOP: sampled one bit period after the last data or parity bit.
  - sin=1, good frame: on the next cycle, if valid=0 or rd=1, load qa..qd and set valid=1. If valid=1 and rd=0, discard the frame, set overrun=1 and leave qa..qd unchanged. Then go to IDLE.
  - sin=0: pulse frame_err for exactly one cycle, do not update data or valid, go to BREAK.
- BREAK: wait until sin=1, then go to IDLE. A start bit cannot be detected before sin has been seen high.
- Latency: valid rises 1 cycle after the stop-bit sample. At BIT_CLKS=4 this is t0+23 (without parity).
- rd:
  - rd=1 with valid=1 clears valid on the next edge; qa..qd hold their value.
  - rd=1 with valid=0 has no effect.
  - rd in the same cycle as a good-frame load: the new frame loads, valid stays 1, no overrun.
  - overrun clears only on an rd that is accepted while valid=1, or on reset.
- msb_first changes mid-frame have no effect until the next start detection.
- Back-to-back frames: a start bit that immediately follows a good stop bit is detected with no idle gap required. IDLE is entered in the cycle after the stop sample.
- Reset asserted mid-frame aborts the frame; no flags are set.

Optional Feature:
- Macro: X74_SERIAL_RX_PARITY_EN.
- Defined: one even-parity bit follows the data bits and is sampled in the PARITY state.
  - Parity mismatch with a good stop bit: treated as a framing error (frame_err pulse, data discarded, go to IDLE).
  - Frame length becomes 7 bits; valid latency becomes t0+27 at BIT_CLKS=4.
- Undefined: no PARITY state; 6-bit frame.

Test Plan:
- Reset: clr=0 mid-frame with sin toggling -> all outputs 0 immediately; the next clean frame is received normally.
- Basic, BIT_CLKS=4, msb_first=1: send data 1,0,1,1 with stop=1 -> qa..qd=1011, valid=1 at t0+23; rd pulse -> valid=0, data held.
- LSB-first, msb_first=0: send 1,0,0,0 -> qd=1, qa=0 (data 0001); toggling msb_first mid-frame does not change the result.
- Glitch and framing: sin low for 1 cycle -> no activity. Stop bit 0 -> frame_err high for exactly 1 cycle, valid stays 0, no start is detected until sin returns high.
- Overrun: two back-to-back frames 0101 then 1110 with no rd -> qa..qd=0101, overrun=1. The next rd -> valid=0, overrun=0. With rd asserted on the load cycle instead -> 1110 loads, overrun=0.
- Parity (X74_SERIAL_RX_PARITY_EN): frame 0111 with parity=1 -> valid=1. Same frame with parity=0 -> frame_err pulse, no valid.
